sort_input_loader: RTL

SORT_INPUT_LOADER -- requirements
Module: sort_input_loader

---
 rtl/sorter_pkg.sv | 13 +
 rtl/loader_slot_counter.sv | 28 ++
 rtl/sort_input_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter input loader: FILL/FULL state encoding
// and the pad value used to top up short frames.
package sorter_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loaderState_t;

  // All-ones sorts last, so padded slots never displace real elements.
  localparam logic [63:0] PAD_VALUE = '1;

endpackage

// File: rtl/loader_slot_counter.sv
// Slot counter for the sorter input loader: counts accepted elements,
// wraps at SLOTS, and flags the last slot of the frame.
module loader_slot_counter #(
  parameter int SLOTS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(SLOTS)-1:0] count,
  output logic                     isLast
);

  localparam int CW = $clog2(SLOTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == CW'(SLOTS - 1)) ? '0 : count + CW'(1);
    end
  end

  assign isLast = (count == CW'(SLOTS - 1));

endmodule

// File: rtl/sort_input_loader.sv
// Collects 2N serial elements into one frame for the odd/even splitter.
// Optional SORT_LOADER_PAD_EN adds in_last and all-ones padding of short frames.
module sort_input_loader
  import sorter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
`ifdef SORT_LOADER_PAD_EN
  input  logic                   in_last,
`endif
  output logic [2*N*WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int SLOTS = 2 * N;
  localparam int CW    = $clog2(SLOTS);
  localparam logic [WIDTH-1:0] PAD = PAD_VALUE[WIDTH-1:0];

  loaderState_t          state, stateNext;
  logic                  inReadyQ;
  logic [2*N*WIDTH-1:0]  frameQ;
  logic [CW-1:0]         slot;
  logic                  slotIsLast;
  logic                  lastIn;
  logic                  accept;
  logic                  padAccept;
  logic                  frameDone;
  logic                  drain;

`ifdef SORT_LOADER_PAD_EN
  assign lastIn = in_last;
`else
  assign lastIn = 1'b0;
`endif

  assign accept    = in_valid && inReadyQ;
  assign padAccept = accept && lastIn && !slotIsLast;
  assign frameDone = accept && (slotIsLast || lastIn);
  assign drain     = (state == FULL) && out_ready;

  loader_slot_counter #(
    .SLOTS (SLOTS)
  ) uSlotCounter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (accept),
    .clr    (padAccept || drain),
    .count  (slot),
    .isLast (slotIsLast)
  );

  always_comb begin
    stateNext = state;
    case (state)
      FILL:    if (frameDone) stateNext = FULL;
      FULL:    if (out_ready) stateNext = FILL;
      default: stateNext = FILL;
    endcase
  end

  // in_ready is registered so it stays low during reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      inReadyQ <= 1'b0;
    end else begin
      state    <= stateNext;
      inReadyQ <= (stateNext == FILL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameQ <= '0;
    end else begin
      for (int unsigned j = 0; j < SLOTS; j++) begin
        if (accept && (CW'(j) == slot)) begin
          frameQ[j*WIDTH +: WIDTH] <= in_data;
        end else if (padAccept && (CW'(j) > slot)) begin
          frameQ[j*WIDTH +: WIDTH] <= PAD;
        end
      end
    end
  end

  assign in_ready  = inReadyQ;
  assign out_data  = frameQ;
  assign out_valid = (state == FULL);

endmodule
